// File: rtl/pipe_control_unit.sv
// Main control for the pipelined MIPS core: decodes the ID opcode into the ID/EX
// control register, inserts bubbles and holds EX while a multi-cycle multiply runs.
module pipe_control_unit #(
  parameter int MUL_CYCLES   = 3,
  parameter int CNT_W        = 4,
  parameter int TRAP_ILLEGAL = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic       IdValid,
  input  logic       Stall,
  input  logic       Flush,
  output logic       IF_Flush,
  output logic       MulBusy,
  output logic       IllegalOp,
  output logic       ExValid,
  output logic       ExRegDst,
  output logic       ExSigned,
  output logic       ExRegWrite,
  output logic       ExALUSrc,
  output logic       ExJump,
  output logic       ExJumpJal,
  output logic       ExSaveRa,
  output logic       ExMemWrite,
  output logic       ExMemRead,
  output logic       ExMemToReg,
  output logic [3:0] ExALUOp,
  output logic [1:0] ExAmt
);

  typedef enum logic [0:0] {RUN = 1'b0, MUL_HOLD = 1'b1} state_t;

  typedef struct packed {
    logic       regdst;
    logic       sgn;
    logic       regwrite;
    logic       alusrc;
    logic [3:0] aluop;
    logic       jump;
    logic       jumpjal;
    logic       savera;
    logic       memwrite;
    logic       memread;
    logic       memtoreg;
    logic [1:0] amt;
  } ctrl_t;

  localparam ctrl_t           CTRL_NOP  = ctrl_t'(16'h0000);
  localparam bit              TRAP_EN   = (TRAP_ILLEGAL != 0);
  localparam bit              MUL_HOLDS = (MUL_CYCLES > 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [5:0]      OP_MUL    = 6'd28;

  function automatic ctrl_t alu_ctrl(input logic rd, input logic sg, input logic rw,
                                     input logic as, input logic [3:0] op);
    ctrl_t c;
    c          = CTRL_NOP;
    c.regdst   = rd;
    c.sgn      = sg;
    c.regwrite = rw;
    c.alusrc   = as;
    c.aluop    = op;
    return c;
  endfunction

  // Load/store size comes from the low opcode bits: x00 byte, x01 half, x11 word.
  function automatic logic [1:0] size_of(input logic [5:0] op);
    logic [1:0] s;
    case (op[1:0])
      2'b00:   s = 2'b01;
      2'b01:   s = 2'b10;
      default: s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    logic l;
    case (op)
      6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11,
      6'd12, 6'd13, 6'd14, 6'd15, 6'd28, 6'd31, 6'd32, 6'd33, 6'd35,
      6'd40, 6'd41, 6'd43: l = 1'b1;
      default:             l = 1'b0;
    endcase
    return l;
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      6'd0, 6'd31:  c = alu_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      6'd8, 6'd9:   c = alu_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 4'b0001);
      6'd12:        c = alu_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 4'b0010);
      6'd13:        c = alu_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 4'b0011);
      6'd14:        c = alu_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 4'b0100);
      6'd10:        c = alu_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 4'b0101);
      6'd11:        c = alu_ctrl(1'b0, 1'b0, 1'b1, 1'b1, 4'b0101);
      6'd28:        c = alu_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 4'b0110);
      6'd15:        c = alu_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 4'b1001);
      6'd32, 6'd33, 6'd35: begin
        c          = alu_ctrl(1'b0, 1'b1, 1'b1, 1'b1, 4'b1000);
        c.memread  = 1'b1;
        c.memtoreg = 1'b1;
        c.amt      = size_of(op);
      end
      6'd40, 6'd41, 6'd43: begin
        c          = alu_ctrl(1'b0, 1'b1, 1'b0, 1'b1, 4'b1000);
        c.memwrite = 1'b1;
        c.amt      = size_of(op);
      end
      6'd1, 6'd4, 6'd5, 6'd6, 6'd7: c = alu_ctrl(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111);
      6'd2:         c.jump = 1'b1;
      6'd3: begin
        c         = alu_ctrl(1'b1, 1'b0, 1'b1, 1'b0, 4'b1111);
        c.jump    = 1'b1;
        c.jumpjal = 1'b1;
        c.savera  = 1'b1;
      end
      default:      c = CTRL_NOP;
    endcase
    return c;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  ctrl_t            ctrl_r, ctrl_nxt_s, dec_s;
  logic             valid_r, valid_nxt_s;
  logic             illegal_r, illegal_nxt_s;
  logic             legal_s;

  assign dec_s   = decode_ctrl(Opcode);
  assign legal_s = is_legal(Opcode);

  // Next-state, hold counter and ID/EX control selection.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    ctrl_nxt_s    = ctrl_r;
    valid_nxt_s   = valid_r;
    illegal_nxt_s = 1'b0;
    case (state_r)
      RUN: begin
        if (Flush || Stall || !IdValid) begin
          ctrl_nxt_s  = CTRL_NOP;
          valid_nxt_s = 1'b0;
        end else if (!legal_s && TRAP_EN) begin
          ctrl_nxt_s    = CTRL_NOP;
          valid_nxt_s   = 1'b0;
          illegal_nxt_s = 1'b1;
        end else begin
          ctrl_nxt_s  = dec_s;
          valid_nxt_s = 1'b1;
          if (Opcode == OP_MUL && MUL_HOLDS) begin
            cnt_nxt_s   = CNT_LOAD;
            state_nxt_s = MUL_HOLD;
          end else begin
            cnt_nxt_s   = cnt_r;
          end
        end
      end
      MUL_HOLD: begin
        // EX keeps the multiply; upstream is frozen so its inputs are not looked at.
        if (cnt_r == CNT_ONE) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = RUN;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cnt_nxt_s   = CNT_ZERO;
        ctrl_nxt_s  = CTRL_NOP;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State and ID/EX control register update.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r   <= RUN;
      cnt_r     <= CNT_ZERO;
      ctrl_r    <= CTRL_NOP;
      valid_r   <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      ctrl_r    <= ctrl_nxt_s;
      valid_r   <= valid_nxt_s;
      illegal_r <= illegal_nxt_s;
    end
  end

  assign MulBusy   = (state_r == MUL_HOLD);
  assign IllegalOp = illegal_r & ~Reset;
  assign IF_Flush  = IdValid & ~Stall & ~MulBusy & ((Opcode == 6'd2) | (Opcode == 6'd3));

  assign ExValid    = valid_r;
  assign ExRegDst   = ctrl_r.regdst;
  assign ExSigned   = ctrl_r.sgn;
  assign ExRegWrite = ctrl_r.regwrite;
  assign ExALUSrc   = ctrl_r.alusrc;
  assign ExALUOp    = ctrl_r.aluop;
  assign ExJump     = ctrl_r.jump;
  assign ExJumpJal  = ctrl_r.jumpjal;
  assign ExSaveRa   = ctrl_r.savera;
  assign ExMemWrite = ctrl_r.memwrite;
  assign ExMemRead  = ctrl_r.memread;
  assign ExMemToReg = ctrl_r.memtoreg;
  assign ExAmt      = ctrl_r.amt;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: two instances (default, and MUL_CYCLES=1/no trap)
// checked every cycle against a table-driven model, plus directed literal checks.
module tb_pipe_control_unit;

  logic       Clk, Reset, IdValid, Stall, Flush;
  logic [5:0] Opcode;

  logic [1:0]  g_iff, g_busy, g_ill, g_valid;
  logic [15:0] g_vec [2];

  logic [15:0] ref_tab [64];
  bit          ref_ok  [64];

  logic [15:0] m_vec  [2];
  logic        m_valid[2];
  logic        m_vchk [2];
  logic        m_ill  [2];
  int          m_hold [2];
  int          mulc   [2];
  bit          trap   [2];

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  int legal_ops[24] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                        28, 31, 32, 33, 35, 40, 41, 43};

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic rd, sg, rw, as, j, jal, sra, mw, mr, m2r;
    logic [3:0] aop;
    logic [1:0] amt;
    pipe_control_unit #(
      .MUL_CYCLES  (gi == 0 ? 3 : 1),
      .CNT_W       (4),
      .TRAP_ILLEGAL(gi == 0 ? 1 : 0)
    ) dut (
      .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .IdValid(IdValid),
      .Stall(Stall), .Flush(Flush),
      .IF_Flush(g_iff[gi]), .MulBusy(g_busy[gi]), .IllegalOp(g_ill[gi]),
      .ExValid(g_valid[gi]), .ExRegDst(rd), .ExSigned(sg), .ExRegWrite(rw),
      .ExALUSrc(as), .ExJump(j), .ExJumpJal(jal), .ExSaveRa(sra),
      .ExMemWrite(mw), .ExMemRead(mr), .ExMemToReg(m2r), .ExALUOp(aop), .ExAmt(amt)
    );
    assign g_vec[gi] = {rd, sg, rw, as, aop, j, jal, sra, mw, mr, m2r, amt};
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] row(input logic rd, sg, rw, as, input logic [3:0] aop,
                                      input logic j, jal, sra, mw, mr, m2r,
                                      input logic [1:0] amt);
    return {rd, sg, rw, as, aop, j, jal, sra, mw, mr, m2r, amt};
  endfunction

  task automatic put(input int op, input logic [15:0] v);
    ref_tab[op] = v;
    ref_ok[op]  = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: advances on every rising edge from the inputs presented during that cycle.
  always @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      if (Reset) begin
        m_vec[i] = 16'h0; m_valid[i] = 1'b0; m_vchk[i] = 1'b1; m_ill[i] = 1'b0; m_hold[i] = 0;
      end else if (m_hold[i] > 0) begin
        m_hold[i] = m_hold[i] - 1;
        m_ill[i]  = 1'b0;
      end else if (Flush || Stall || !IdValid) begin
        m_vec[i] = 16'h0; m_valid[i] = 1'b0; m_vchk[i] = 1'b1; m_ill[i] = 1'b0;
      end else if (!ref_ok[Opcode]) begin
        m_vec[i]   = 16'h0;
        m_valid[i] = 1'b0;
        m_vchk[i]  = trap[i];
        m_ill[i]   = trap[i];
      end else begin
        m_vec[i] = ref_tab[Opcode]; m_valid[i] = 1'b1; m_vchk[i] = 1'b1; m_ill[i] = 1'b0;
        if (Opcode == 6'd28) m_hold[i] = mulc[i] - 1;
      end
    end
  end

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("d%0d_vec", i), 32'(g_vec[i]), 32'(m_vec[i]));
        if (m_vchk[i]) chk($sformatf("d%0d_valid", i), 32'(g_valid[i]), 32'(m_valid[i]));
        chk($sformatf("d%0d_busy", i), 32'(g_busy[i]), 32'(m_hold[i] > 0));
        chk($sformatf("d%0d_illegal", i), 32'(g_ill[i]), 32'(m_ill[i] & ~Reset));
        chk($sformatf("d%0d_if_flush", i), 32'(g_iff[i]),
            32'(IdValid & ~Stall & (m_hold[i] == 0) & (Opcode == 6'd2 || Opcode == 6'd3)));
      end
    end
  end

  task automatic cyc(input logic [5:0] op, input logic v, s, f, r);
    @(posedge Clk);
    #1;
    Opcode = op; IdValid = v; Stall = s; Flush = f; Reset = r;
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; Opcode = 6'd0; IdValid = 1'b0; Stall = 1'b0; Flush = 1'b0;
    mulc[0] = 3; trap[0] = 1'b1;
    mulc[1] = 1; trap[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_vec[i] = 16'h0; m_valid[i] = 1'b0; m_vchk[i] = 1'b1; m_ill[i] = 1'b0; m_hold[i] = 0;
    end
    for (int k = 0; k < 64; k++) begin ref_tab[k] = 16'h0; ref_ok[k] = 1'b0; end
    put(0,  row(1,1,1,0,4'b0000, 0,0,0,0,0,0,2'b00));
    put(31, row(1,1,1,0,4'b0000, 0,0,0,0,0,0,2'b00));
    put(8,  row(0,1,1,1,4'b0001, 0,0,0,0,0,0,2'b00));
    put(9,  row(0,1,1,1,4'b0001, 0,0,0,0,0,0,2'b00));
    put(12, row(0,0,1,1,4'b0010, 0,0,0,0,0,0,2'b00));
    put(13, row(0,0,1,1,4'b0011, 0,0,0,0,0,0,2'b00));
    put(14, row(0,0,1,1,4'b0100, 0,0,0,0,0,0,2'b00));
    put(10, row(0,1,1,1,4'b0101, 0,0,0,0,0,0,2'b00));
    put(11, row(0,0,1,1,4'b0101, 0,0,0,0,0,0,2'b00));
    put(28, row(1,1,1,0,4'b0110, 0,0,0,0,0,0,2'b00));
    put(15, row(0,1,1,1,4'b1001, 0,0,0,0,0,0,2'b00));
    put(35, row(0,1,1,1,4'b1000, 0,0,0,0,1,1,2'b00));
    put(32, row(0,1,1,1,4'b1000, 0,0,0,0,1,1,2'b01));
    put(33, row(0,1,1,1,4'b1000, 0,0,0,0,1,1,2'b10));
    put(43, row(0,1,0,1,4'b1000, 0,0,0,1,0,0,2'b00));
    put(40, row(0,1,0,1,4'b1000, 0,0,0,1,0,0,2'b01));
    put(41, row(0,1,0,1,4'b1000, 0,0,0,1,0,0,2'b10));
    foreach (legal_ops[k]) if (legal_ops[k] >= 1 && legal_ops[k] <= 7 && legal_ops[k] != 2 && legal_ops[k] != 3)
      put(legal_ops[k], row(0,1,0,0,4'b1111, 0,0,0,0,0,0,2'b00));
    put(2,  row(0,0,0,0,4'b0000, 1,0,0,0,0,0,2'b00));
    put(3,  row(1,0,1,0,4'b1111, 1,1,1,0,0,0,2'b00));

    cyc(6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    chk("reset_valid", 32'(g_valid[0]), 32'd0);
    chk("reset_vec", 32'(g_vec[0]), 32'd0);
    chk("reset_busy", 32'(g_busy[0]), 32'd0);

    // Directed: LH-style load, stall bubble, flush bubble with J/Jal kill.
    cyc(6'd33, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(6'd8,  1'b1, 1'b1, 1'b0, 1'b0);
    chk("lit_op33_vec", 32'(g_vec[0]), 32'(16'b0111_1000_000011_10));
    chk("lit_op33_valid", 32'(g_valid[0]), 32'd1);
    cyc(6'd3,  1'b1, 1'b0, 1'b1, 1'b0);
    chk("lit_stall_vec", 32'(g_vec[0]), 32'd0);
    chk("lit_stall_valid", 32'(g_valid[0]), 32'd0);
    chk("lit_flush_iff", 32'(g_iff[0]), 32'd1);
    // Multiply occupies EX cycles 1..3, busy in cycles 1..2.
    cyc(6'd28, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_flush_bubble", 32'(g_vec[0]), 32'd0);
    cyc(6'd3,  1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_mul_c1_aluop", 32'(g_vec[0][11:8]), 32'(4'b0110));
    chk("lit_mul_c1_busy", 32'(g_busy[0]), 32'd1);
    chk("lit_mul_c1_iff", 32'(g_iff[0]), 32'd0);
    cyc(6'd17, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_mul_c2_aluop", 32'(g_vec[0][11:8]), 32'(4'b0110));
    chk("lit_mul_c2_busy", 32'(g_busy[0]), 32'd1);
    cyc(6'd43, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_mul_c3_aluop", 32'(g_vec[0][11:8]), 32'(4'b0110));
    chk("lit_mul_c3_busy", 32'(g_busy[0]), 32'd0);
    cyc(6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_sw_vec", 32'(g_vec[0]), 32'(16'b0101_1000_000100_00));
    chk("lit_sw_illegal", 32'(g_ill[0]), 32'd0);
    // Consecutive illegal opcodes give one pulse each; untrapped instance stays quiet.
    cyc(6'd17, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(6'd17, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_ill1", 32'(g_ill[0]), 32'd1);
    chk("lit_ill1_valid", 32'(g_valid[0]), 32'd0);
    chk("lit_ill_notrap", 32'(g_ill[1]), 32'd0);
    chk("lit_ill_notrap_vec", 32'(g_vec[1]), 32'd0);
    cyc(6'd2,  1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_ill2", 32'(g_ill[0]), 32'd1);
    chk("lit_j_iff", 32'(g_iff[0]), 32'd1);
    cyc(6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_ill_end", 32'(g_ill[0]), 32'd0);
    chk("lit_j_vec", 32'(g_vec[0]), 32'(16'b0000_0000_100000_00));
    // Reset during the second busy cycle abandons the multiply.
    cyc(6'd28, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    cyc(6'd0,  1'b0, 1'b0, 1'b0, 1'b1);
    chk("lit_rst_hold_busy", 32'(g_busy[0]), 32'd1);
    cyc(6'd35, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lit_rst_vec", 32'(g_vec[0]), 32'd0);
    chk("lit_rst_busy", 32'(g_busy[0]), 32'd0);
    cyc(6'd0,  1'b0, 1'b0, 1'b0, 1'b0);
    chk("lit_lw_vec", 32'(g_vec[0]), 32'(16'b0111_1000_000011_00));
    chk("lit_lw_valid", 32'(g_valid[0]), 32'd1);

    // Table sweep, back-to-back multiplies, then randomized traffic.
    foreach (legal_ops[k]) cyc(6'(legal_ops[k]), 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) cyc(6'd28, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 800; n++) begin
      int r;
      logic [5:0] op;
      r = int'($urandom_range(0, 99));
      if (r < 55)      op = 6'(legal_ops[$urandom_range(0, 23)]);
      else if (r < 75) op = 6'd28;
      else             op = 6'($urandom_range(0, 63));
      cyc(op, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 12),
          ($urandom_range(0, 99) < 12), ($urandom_range(0, 99) < 2));
    end
    cyc(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
